// File: rtl/bcd_display_scanner.sv
// Four-digit BCD scanner for a multiplexed 7-segment display with guard time, blanking and error flag.
// Optional macro DISPLAY_DIM_EN adds in_brightness and PWM dimming of the anodes.
module bcd_display_scanner #(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned GUARD          = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic [15:0] in_bcd_value,
    input  logic        in_load,
    input  logic        in_enable,
    input  logic        in_blank_lz,
    input  logic [3:0]  in_dp,
`ifdef DISPLAY_DIM_EN
    input  logic [3:0]  in_brightness,
`endif
    output logic [6:0]  out_seg,
    output logic        out_dp,
    output logic [3:0]  out_an,
    output logic        out_frame_sync,
    output logic        out_bcd_err
);

    localparam int unsigned     CntW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] GuardLast = CntW'(GUARD - 1);
    localparam logic [CntW-1:0] SlotLast  = CntW'(REFRESH_DIV - 1);
    localparam logic [6:0]      SegOff    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic            DpOff     = SEG_ACTIVE_LOW;
    localparam logic [3:0]      AnOff     = AN_ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic [1:0] {StOff, StGuard, StDrive} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     pend_q, pend_d;
    logic [3:0]      pend_dp_q, pend_dp_d;
    logic            pend_valid_q, pend_valid_d;
    logic [15:0]     disp_q, disp_d;
    logic [3:0]      disp_dp_q, disp_dp_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [3:0]      an_q, an_d;
    logic            frame_sync_q, frame_sync_d;
    logic            bcd_err_q, bcd_err_d;

    logic            slot_start;
    logic            frame_start;
    logic [3:0]      digit;
    logic [3:0]      lead_zero;
    logic [6:0]      seg_raw;
    logic [3:0]      an_raw;
    logic            an_on;

`ifdef DISPLAY_DIM_EN
    logic [3:0] pwm_q, pwm_d;
    assign pwm_d = pwm_q + 4'd1;
    assign an_on = (pwm_d <= in_brightness);
`else
    assign an_on = 1'b1;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    function automatic logic has_bad_nibble(input logic [15:0] w);
        return (w[15:12] > 4'd9) || (w[11:8] > 4'd9) || (w[7:4] > 4'd9) || (w[3:0] > 4'd9);
    endfunction

    // Scan sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!in_enable) begin
            state_d = StOff;
            cnt_d   = '0;
            idx_d   = 2'd0;
        end else begin
            case (state_q)
                StOff: begin
                    state_d = StGuard;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                end
                StGuard: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == GuardLast) state_d = StDrive;
                end
                StDrive: begin
                    if (cnt_q == SlotLast) begin
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        state_d = StGuard;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StOff;
            endcase
        end
    end

    assign slot_start  = (state_d == StGuard) && (cnt_d == '0);
    assign frame_start = slot_start && (idx_d == 2'd0);

    // Commit uses the old pending word; a simultaneous load refills pending afterwards.
    always_comb begin
        pend_d       = pend_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        disp_d       = disp_q;
        disp_dp_d    = disp_dp_q;
        bcd_err_d    = bcd_err_q;
        if (frame_start && pend_valid_q) begin
            disp_d       = pend_q;
            disp_dp_d    = pend_dp_q;
            pend_valid_d = 1'b0;
            bcd_err_d    = has_bad_nibble(pend_q);
        end
        if (in_load) begin
            pend_d       = in_bcd_value;
            pend_dp_d    = in_dp;
            pend_valid_d = 1'b1;
        end
    end

    // Segments are latched at slot entry so they settle during the guard interval.
    always_comb begin
        lead_zero[3] = (disp_d[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (disp_d[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (disp_d[7:4] == 4'd0);
        lead_zero[0] = 1'b0;
        digit        = disp_d[{idx_d, 2'b00} +: 4];
        seg_raw      = (in_blank_lz && lead_zero[idx_d]) ? 7'h00 : seg_decode(digit);

        seg_d = seg_q;
        dp_d  = dp_q;
        if (state_d == StOff) begin
            seg_d = SegOff;
            dp_d  = DpOff;
        end else if (slot_start) begin
            seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
            dp_d  = disp_dp_d[idx_d] ^ SEG_ACTIVE_LOW;
        end

        an_raw       = (state_d == StDrive && an_on) ? (4'b0001 << idx_d) : 4'b0000;
        an_d         = an_raw ^ {4{AN_ACTIVE_LOW}};
        frame_sync_d = frame_start;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q      <= StOff;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            pend_q       <= 16'h0000;
            pend_dp_q    <= 4'h0;
            pend_valid_q <= 1'b0;
            disp_q       <= 16'h0000;
            disp_dp_q    <= 4'h0;
            seg_q        <= SegOff;
            dp_q         <= DpOff;
            an_q         <= AnOff;
            frame_sync_q <= 1'b0;
            bcd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_sync_q <= frame_sync_d;
            bcd_err_q    <= bcd_err_d;
        end
    end

`ifdef DISPLAY_DIM_EN
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) pwm_q <= 4'd0;
        else           pwm_q <= pwm_d;
    end
`endif

    assign out_seg        = seg_q;
    assign out_dp         = dp_q;
    assign out_an         = an_q;
    assign out_frame_sync = frame_sync_q;
    assign out_bcd_err    = bcd_err_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: directed steps plus random traffic against a time-based reference model.
module tb_bcd_display_scanner;

    localparam int RD = 8;
    localparam int G  = 2;
    localparam int FR = 4 * RD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bcd;
    logic        load, en, blz;
    logic [3:0]  dpin;
    logic [6:0]  out_seg;
    logic        out_dp;
    logic [3:0]  out_an;
    logic        out_frame_sync, out_bcd_err;

    always #5 clk = ~clk;

    bcd_display_scanner #(
        .REFRESH_DIV   (RD),
        .GUARD         (G),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .in_clk        (clk),
        .in_rst_n      (rst_n),
        .in_bcd_value  (bcd),
        .in_load       (load),
        .in_enable     (en),
        .in_blank_lz   (blz),
        .in_dp         (dpin),
`ifdef DISPLAY_DIM_EN
        .in_brightness (4'hF),
`endif
        .out_seg       (out_seg),
        .out_dp        (out_dp),
        .out_an        (out_an),
        .out_frame_sync(out_frame_sync),
        .out_bcd_err   (out_bcd_err)
    );

    // Reference model: t counts cycles since the scan (re)started, -1 while dark.
    int          t;
    logic [15:0] m_pend, m_disp;
    logic [3:0]  m_pdp, m_ddp;
    bit          m_pv, m_err, m_dpon;
    logic [6:0]  m_seg;
    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;

    function automatic logic [6:0] seg_of(input int n);
        case (n)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic bit any_bad(input logic [15:0] v);
        for (int i = 0; i < 4; i++) if (((v >> (4 * i)) & 16'hF) > 9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = -1; m_pend = 0; m_disp = 0; m_pdp = 0; m_ddp = 0;
        m_pv = 0; m_err = 0; m_seg = 0; m_dpon = 0;
    endtask

    task automatic model_edge();
        int k;
        if (!en) begin
            t = -1; m_seg = 0; m_dpon = 0;
        end else begin
            t = (t < 0) ? 0 : t + 1;
            if (t % FR == 0 && m_pv) begin
                m_disp = m_pend; m_ddp = m_pdp; m_pv = 0; m_err = any_bad(m_pend);
            end
            if (t % RD == 0) begin
                k = (t / RD) % 4;
                if (blz && k > 0 && (m_disp >> (4 * k)) == 0) m_seg = 7'h00;
                else m_seg = seg_of(int'((m_disp >> (4 * k)) & 16'hF));
                m_dpon = m_ddp[k];
            end
        end
        if (load) begin
            m_pend = bcd; m_pdp = dpin; m_pv = 1;
        end
    endtask

    task automatic check_outputs();
        logic [3:0] an_act, an_pin;
        logic [6:0] seg_pin;
        logic       dp_pin, sync_exp;
        an_act   = (t >= 0 && t % RD >= G) ? 4'(1 << ((t / RD) % 4)) : 4'h0;
        an_pin   = ~an_act;
        seg_pin  = ~m_seg;
        dp_pin   = ~m_dpon;
        sync_exp = (t >= 0 && t % FR == 0);
        check("an", out_an, an_pin);
        check("seg", out_seg, seg_pin);
        check("dp", out_dp, dp_pin);
        check("sync", out_frame_sync, sync_exp);
        check("err", out_bcd_err, m_err);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run_to(input int slot, input int phase);
        bit reached = 0;
        for (int i = 0; i < 2 * FR + 2; i++) begin
            if (t >= 0 && t % FR == slot * RD + phase) begin
                reached = 1;
                break;
            end
            step();
        end
        check("run_to_reached", reached, 1'b1);
    endtask

    task automatic dig(input string tag, input int k, input logic [6:0] seg_act, input bit dp_act);
        logic [6:0] sp;
        logic [3:0] ap;
        logic       dp;
        run_to(k, G + 1);
        sp = ~seg_act;
        ap = ~(4'(1 << k));
        dp = ~dp_act;
        check({tag, "_seg"}, out_seg, sp);
        check({tag, "_dp"}, out_dp, dp);
        check({tag, "_an"}, out_an, ap);
    endtask

    task automatic load_word(input logic [15:0] v);
        bcd = v; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_an"}, out_an, 4'hF);
        check({tag, "_seg"}, out_seg, 7'h7F);
        check({tag, "_dp"}, out_dp, 1'b1);
        check({tag, "_sync"}, out_frame_sync, 1'b0);
        check({tag, "_err"}, out_bcd_err, 1'b0);
    endtask

    initial begin
        int n_d0, n_sync, lat;
        rst_n = 1'b0; bcd = 16'h0; load = 0; en = 0; blz = 0; dpin = 4'h0;
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();

        // Free run: scan order, duty and frame sync period.
        en = 1'b1;
        n_d0 = 0; n_sync = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            step();
            if (out_an === 4'b1110) n_d0++;
            if (out_frame_sync === 1'b1) n_sync++;
        end
        check("digit0_active_cycles", n_d0, 2 * (RD - G));
        check("sync_count", n_sync, 2);

        // Mid-frame load becomes visible only after the next frame sync.
        run_to(1, 3);
        load_word(16'h1234);
        lat = 1;
        for (int i = 0; i < 40; i++) begin
            if (out_frame_sync === 1'b1) break;
            step();
            lat++;
        end
        check("latency_le_33", (lat <= FR + 1), 1'b1);
        dig("v1234_d0", 0, 7'h66, 0);
        dig("v1234_d1", 1, 7'h4F, 0);
        dig("v1234_d2", 2, 7'h5B, 0);
        dig("v1234_d3", 3, 7'h06, 0);

        blz = 1'b1;
        load_word(16'h0042);
        dig("v0042_d0", 0, 7'h5B, 0);
        dig("v0042_d1", 1, 7'h66, 0);
        dig("v0042_d2", 2, 7'h00, 0);
        dig("v0042_d3", 3, 7'h00, 0);

        dpin = 4'b0100;
        load_word(16'h0000);
        dpin = 4'b0000;
        dig("v0000_d0", 0, 7'h3F, 0);
        dig("v0000_d1", 1, 7'h00, 0);
        dig("v0000_d2", 2, 7'h00, 1);
        dig("v0000_d3", 3, 7'h00, 0);

        blz = 1'b0;
        load_word(16'h1A23);
        dig("v1a23_d2", 2, 7'h40, 0);
        check("v1a23_err", out_bcd_err, 1'b1);
        load_word(16'h1023);
        check("err_held", out_bcd_err, 1'b1);
        run_to(0, 3);
        check("err_cleared", out_bcd_err, 1'b0);

        // Newest pending word wins.
        run_to(1, 0);
        load_word(16'h5555);
        repeat (5) step();
        load_word(16'h6666);
        dig("newest_d1", 1, 7'h7D, 0);

        // Disable mid-drive, then re-enable from a digit-0 guard slot.
        run_to(1, 4);
        en = 1'b0;
        step();
        check("dark_an", out_an, 4'hF);
        check("dark_seg", out_seg, 7'h7F);
        repeat (3) step();
        en = 1'b1;
        step();
        check("restart_sync", out_frame_sync, 1'b1);
        check("restart_guard_an", out_an, 4'hF);
        dig("restart_d0", 0, 7'h7D, 0);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            logic [15:0] w;
            w = 16'h0;
            for (int j = 0; j < 4; j++)
                if ($urandom_range(2) != 0) w[4*j +: 4] = 4'($urandom_range(11));
            bcd  = w;
            dpin = 4'($urandom);
            load = ($urandom_range(7) == 0);
            if ($urandom_range(15) == 0) blz = ~blz;
            en   = ($urandom_range(149) != 0);
            step();
        end
        load = 1'b0; en = 1'b1; blz = 1'b0;

        // Asynchronous reset mid-frame discards an uncommitted word.
        run_to(0, 3);
        load_word(16'h9999);
        run_to(2, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        dig("post_reset_d0", 0, 7'h3F, 0);
        dig("post_reset_d3", 3, 7'h3F, 0);
        run_to(0, 3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
